// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller.
//   state_t      : controller state encoding (also visible on the debug port)
//   OP_* / F3_* / F7_* : opcode and function-field constants of the supported subset
//   ALU_*, IMM_*, SRCA_*, SRCB_*, RES_*, ALUOP_* : control-field encodings
//   is_legal()   : true for the supported instruction combinations
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Operation class handed to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
        case (op)
            OP_R:      return (f3 == F3_ADD) && ((f7 == F7_ADD) || (f7 == F7_SUB));
            OP_I:      return (f3 == F3_ADD);
            OP_LOAD:   return (f3 == F3_LW);
            OP_STORE:  return (f3 == F3_SW);
            OP_BRANCH: return (f3 == F3_BEQ) || (f3 == F3_BNE);
            OP_JAL:    return 1'b1;
            OP_LUI:    return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake between the controller (master) and the memory (slave).
//   mem_req   : request, held until mem_ready
//   mem_we    : store strobe, meaningful only with mem_req
//   adr_src   : address select, 0 = PC, 1 = ALUOut
//   mem_ready : acknowledge from memory
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
//   alu_op   : operation class from the controller (add / sub / by funct)
//   funct3/7 : instruction function fields
//   alu_ctrl : ALU operation code
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] alu_ctrl
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                if ((funct3 == F3_ADD) && (funct7 == F7_SUB)) begin
                    alu_ctrl = ALU_SUB;
                end
            end
            default:     alu_ctrl = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32 subset datapath.
//   clk, rst        : clock, asynchronous active-low reset
//   ir, EQ          : latched instruction and ALU equality flag
//   mem             : memory handshake (master side)
//   ir_we, pc_we, RegWrite : write enables
//   ALUsrcA/B, ALUctrl, ImmSrc, result_src : datapath steering
//   illegal         : sticky unsupported-instruction flag
//   state           : debug view of the current state
module multicycle_control
    import mc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          ir,
    input  logic                 EQ,
    multicycle_control_if.master mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 RegWrite,
    output logic [1:0]           ALUsrcA,
    output logic [1:0]           ALUsrcB,
    output logic [2:0]           ALUctrl,
    output logic [2:0]           ImmSrc,
    output logic [1:0]           result_src,
    output logic                 illegal,
    output logic [3:0]           state
);
    state_t     state_reg, state_next;
    logic       illegal_reg;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [1:0] alu_op;
    logic       mem_req_c, mem_we_c, adr_src_c, ir_we_c, pc_we_c, reg_write_c;
    logic       unused_ir_bits;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    // Register and immediate fields belong to the datapath.
    assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_ctrl (ALUctrl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next == S_TRAP) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        adr_src_c   = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        reg_write_c = 1'b0;
        ALUsrcA     = SRCA_PC;
        ALUsrcB     = SRCB_RS2;
        ImmSrc      = IMM_I;
        result_src  = RES_ALUOUT;
        alu_op      = ALUOP_ADD;

        case (state_reg)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                ALUsrcB    = SRCB_FOUR;
                result_src = RES_ALU;
                if (mem.mem_ready) begin
                    ir_we_c    = 1'b1;
                    pc_we_c    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target is formed here so BRANCH/JAL can use ALUOut.
                ALUsrcA = SRCA_OLDPC;
                ALUsrcB = SRCB_IMM;
                ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                if (!is_legal(opcode, funct3, funct7)) begin
                    state_next = S_TRAP;
                end else begin
                    case (opcode)
                        OP_R:              state_next = S_EXEC_R;
                        OP_I, OP_LUI:      state_next = S_EXEC_I;
                        OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        default:           state_next = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R: begin
                ALUsrcA    = SRCA_RS1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                // lui is computed as 0 + U-immediate.
                ALUsrcA    = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_RS1;
                ALUsrcB    = SRCB_IMM;
                ImmSrc     = (opcode == OP_LUI) ? IMM_U : IMM_I;
                state_next = S_WB_ALU;
            end
            S_MEM_ADR: begin
                ALUsrcA    = SRCA_RS1;
                ALUsrcB    = SRCB_IMM;
                ImmSrc     = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem.mem_ready) state_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                adr_src_c = 1'b1;
                if (mem.mem_ready) state_next = S_FETCH;
            end
            S_WB_ALU: begin
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write_c = 1'b1;
                result_src  = RES_MEM;
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                ALUsrcA    = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                pc_we_c    = ((funct3 == F3_BEQ) & EQ) | ((funct3 == F3_BNE) & ~EQ);
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUsrcA    = SRCA_OLDPC;
                ALUsrcB    = SRCB_FOUR;
                pc_we_c    = 1'b1;
                state_next = S_WB_ALU;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_TRAP;
        endcase
    end

    // Reset kills every strobe combinationally so an in-flight write never completes.
    assign mem.mem_req = mem_req_c & rst;
    assign mem.mem_we  = mem_we_c & rst;
    assign mem.adr_src = adr_src_c;
    assign ir_we       = ir_we_c & rst;
    assign pc_we       = pc_we_c & rst;
    assign RegWrite    = reg_write_c & rst;
    assign illegal     = illegal_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ir  = 32'h0;
    logic        EQ  = 1'b0;
    logic        ir_we, pc_we, RegWrite, illegal;
    logic [1:0]  ALUsrcA, ALUsrcB, result_src;
    logic [2:0]  ALUctrl, ImmSrc;
    logic [3:0]  state;

    multicycle_control_if mem_bus ();

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .ir         (ir),
        .EQ         (EQ),
        .mem        (mem_bus),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .RegWrite   (RegWrite),
        .ALUsrcA    (ALUsrcA),
        .ALUsrcB    (ALUsrcB),
        .ALUctrl    (ALUctrl),
        .ImmSrc     (ImmSrc),
        .result_src (result_src),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef enum int {K_ADD, K_SUB, K_ADDI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_ILL} kind_t;
    typedef enum int {P_RESET, P_FETCH, P_DECODE, P_EXEC_R, P_EXEC_I, P_MEM_ADR, P_MEM_RD,
                      P_MEM_WR, P_WB_ALU, P_WB_MEM, P_BRANCH, P_JAL, P_TRAP} phase_t;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, adr, irwe, pcwe, rw;
        logic [1:0] a, b;
        logic [2:0] alu, imm;
        logic [1:0] res;
        logic       ill;
    } obs_t;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic obs_t sample();
        return {state, mem_bus.mem_req, mem_bus.mem_we, mem_bus.adr_src, ir_we, pc_we,
                RegWrite, ALUsrcA, ALUsrcB, ALUctrl, ImmSrc, result_src, illegal};
    endfunction

    // Expected outputs of one cycle, straight from the output table; m marks the fields
    // that the table defines for that phase.
    function automatic void model(input phase_t p, input kind_t k, input logic eq,
                                  input logic rdy, output obs_t e, output obs_t m);
        e = '0;
        m = '0;
        m.st = '1; m.req = '1; m.we = '1; m.irwe = '1; m.pcwe = '1; m.rw = '1; m.ill = '1;
        case (p)
            P_RESET: e.st = S_FETCH;
            P_FETCH: begin
                e.st = S_FETCH; e.req = 1'b1; e.irwe = rdy; e.pcwe = rdy;
                e.b = 2'b10; e.res = 2'b10;
                m.adr = '1; m.a = '1; m.b = '1; m.alu = '1; m.res = '1;
            end
            P_DECODE: begin
                e.st = S_DECODE; e.a = 2'b01; e.b = 2'b01;
                e.imm = (k == K_JAL) ? 3'b011 : 3'b010;
                m.a = '1; m.b = '1; m.imm = '1; m.alu = '1;
            end
            P_EXEC_R: begin
                e.st = S_EXEC_R; e.a = 2'b10; e.b = 2'b00;
                e.alu = (k == K_SUB) ? 3'b001 : 3'b000;
                m.a = '1; m.b = '1; m.alu = '1;
            end
            P_EXEC_I: begin
                e.st = S_EXEC_I; e.a = (k == K_LUI) ? 2'b11 : 2'b10; e.b = 2'b01;
                e.imm = (k == K_LUI) ? 3'b100 : 3'b000;
                m.a = '1; m.b = '1; m.imm = '1; m.alu = '1;
            end
            P_MEM_ADR: begin
                e.st = S_MEM_ADR; e.a = 2'b10; e.b = 2'b01;
                e.imm = (k == K_SW) ? 3'b001 : 3'b000;
                m.a = '1; m.b = '1; m.imm = '1; m.alu = '1;
            end
            P_MEM_RD: begin
                e.st = S_MEM_RD; e.req = 1'b1; e.adr = 1'b1; m.adr = '1;
            end
            P_MEM_WR: begin
                e.st = S_MEM_WR; e.req = 1'b1; e.we = 1'b1; e.adr = 1'b1; m.adr = '1;
            end
            P_WB_ALU: begin
                e.st = S_WB_ALU; e.rw = 1'b1; m.res = '1;
            end
            P_WB_MEM: begin
                e.st = S_WB_MEM; e.rw = 1'b1; e.res = 2'b01; m.res = '1;
            end
            P_BRANCH: begin
                e.st = S_BRANCH; e.a = 2'b10; e.b = 2'b00; e.alu = 3'b001;
                e.pcwe = (k == K_BEQ) ? eq : ~eq;
                m.a = '1; m.b = '1; m.alu = '1; m.res = '1;
            end
            P_JAL: begin
                e.st = S_JAL; e.a = 2'b01; e.b = 2'b10; e.pcwe = 1'b1;
                m.a = '1; m.b = '1; m.alu = '1; m.res = '1;
            end
            P_TRAP: begin
                e.st = S_TRAP; e.ill = 1'b1;
            end
            default: e.st = S_FETCH;
        endcase
    endfunction

    task automatic check(input string tag, input obs_t o, input obs_t e, input obs_t m);
        n_checks++;
        assert ((o & m) === (e & m)) n_pass++;
        else $error("FAIL %s: observed %h expected %h (care %h)", tag, o & m, e & m, m);
    endtask

    task automatic step(input string tag, input phase_t p, input kind_t k, input logic eq,
                        input logic rdy);
        obs_t e, m;
        @(negedge clk);
        mem_bus.mem_ready = rdy;
        #1;
        model(p, k, eq, rdy, e, m);
        check($sformatf("%s/%s", tag, p.name()), sample(), e, m);
    endtask

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(input string tag);
        obs_t e, m;
        @(negedge clk);
        rst = 1'b0;
        mem_bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            model(P_RESET, K_ADD, 1'b0, 1'b0, e, m);
            check($sformatf("%s/reset%0d", tag, i), sample(), e, m);
            @(negedge clk);
        end
        rst = 1'b1;
        $display("txn reset %s", tag);
    endtask

    task automatic run_instr(input string tag, input logic [31:0] instr, input kind_t k,
                             input logic eq, input int wf, input int wm);
        ir = instr;
        EQ = eq;
        for (int i = 0; i <= wf; i++) step(tag, P_FETCH, k, eq, i == wf);
        step(tag, P_DECODE, k, eq, noise());
        case (k)
            K_ADD, K_SUB: begin
                step(tag, P_EXEC_R, k, eq, noise());
                step(tag, P_WB_ALU, k, eq, noise());
            end
            K_ADDI, K_LUI: begin
                step(tag, P_EXEC_I, k, eq, noise());
                step(tag, P_WB_ALU, k, eq, noise());
            end
            K_LW: begin
                step(tag, P_MEM_ADR, k, eq, noise());
                for (int i = 0; i <= wm; i++) step(tag, P_MEM_RD, k, eq, i == wm);
                step(tag, P_WB_MEM, k, eq, noise());
            end
            K_SW: begin
                step(tag, P_MEM_ADR, k, eq, noise());
                for (int i = 0; i <= wm; i++) step(tag, P_MEM_WR, k, eq, i == wm);
            end
            K_BEQ, K_BNE: step(tag, P_BRANCH, k, eq, noise());
            K_JAL: begin
                step(tag, P_JAL, k, eq, noise());
                step(tag, P_WB_ALU, k, eq, noise());
            end
            default: begin
                for (int i = 0; i < 3; i++) step(tag, P_TRAP, k, eq, noise());
            end
        endcase
        $display("txn %s ir=%h kind=%s eq=%0d wf=%0d wm=%0d", tag, instr, k.name(), eq, wf, wm);
        if (k == K_ILL) do_reset({tag, "_trap"});
    endtask

    function automatic logic [31:0] make_instr(input kind_t k);
        logic [31:0] x;
        x = $urandom();
        case (k)
            K_ADD:  begin x[6:0] = 7'b0110011; x[14:12] = 3'b000; x[31:25] = 7'b0000000; end
            K_SUB:  begin x[6:0] = 7'b0110011; x[14:12] = 3'b000; x[31:25] = 7'b0100000; end
            K_ADDI: begin x[6:0] = 7'b0010011; x[14:12] = 3'b000; end
            K_LUI:  x[6:0] = 7'b0110111;
            K_LW:   begin x[6:0] = 7'b0000011; x[14:12] = 3'b010; end
            K_SW:   begin x[6:0] = 7'b0100011; x[14:12] = 3'b010; end
            K_BEQ:  begin x[6:0] = 7'b1100011; x[14:12] = 3'b000; end
            K_BNE:  begin x[6:0] = 7'b1100011; x[14:12] = 3'b001; end
            K_JAL:  x[6:0] = 7'b1101111;
            default: begin
                case ($urandom_range(0, 5))
                    0: x[6:0] = 7'h7F;
                    1: x[6:0] = 7'h17;
                    2: x[6:0] = 7'h67;
                    3: begin x[6:0] = 7'b0110011; x[14:12] = 3'b000; x[31:25] = 7'b0000001; end
                    4: begin x[6:0] = 7'b0010011; x[14:12] = 3'b001; end
                    default: begin x[6:0] = 7'b1100011; x[14:12] = 3'b100; end
                endcase
            end
        endcase
        return x;
    endfunction

    initial begin
        obs_t  e, m;
        kind_t k;
        mem_bus.mem_ready = 1'b0;

        do_reset("initial");
        run_instr("add",     32'h002081B3, K_ADD, 1'b0, 0, 0);
        run_instr("sub_wait", 32'h402081B3, K_SUB, 1'b0, 2, 0);
        run_instr("bne_eq1", 32'h00209463, K_BNE, 1'b1, 0, 0);
        run_instr("bne_eq0", 32'h00209463, K_BNE, 1'b0, 0, 0);
        run_instr("lw_wait", 32'h0000A183, K_LW, 1'b0, 0, 1);
        run_instr("sw_wait", 32'h0020A023, K_SW, 1'b0, 0, 1);

        for (int n = 0; n < 60; n++) begin
            k = kind_t'($urandom_range(0, 9));
            run_instr($sformatf("rnd%0d", n), make_instr(k), k, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        run_instr("op7f", 32'h0000007F, K_ILL, 1'b0, 0, 0);

        // Reset in the middle of a store access: the strobe must drop at once.
        ir = 32'h0020A023;
        EQ = 1'b0;
        step("sw_rst", P_FETCH, K_SW, 1'b0, 1'b1);
        step("sw_rst", P_DECODE, K_SW, 1'b0, 1'b0);
        step("sw_rst", P_MEM_ADR, K_SW, 1'b0, 1'b0);
        step("sw_rst", P_MEM_WR, K_SW, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model(P_RESET, K_SW, 1'b0, 1'b0, e, m);
        check("sw_rst/mid_write", sample(), e, m);
        $display("txn sw_rst ir=%h reset during MEM_WR", ir);
        do_reset("after_sw_rst");
        run_instr("add_after", 32'h002081B3, K_ADD, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 ir  in  32  latched instruction; opcode ir[6:0], funct3 ir[14:12], funct7 ir[31:25].
REQ-004 EQ  in  1  ALU equality flag (rs1 == rs2), valid in BRANCH.
REQ-005 mem_ready  in  1  memory acknowledge for current request.
REQ-006 mem_req  out  1  memory request, held high until acknowledged.
REQ-007 mem_we  out  1  store strobe, qualified by mem_req.
REQ-008 adr_src  out  1  memory address source: 0 = PC, 1 = ALUOut.
REQ-009 ir_we, pc_we, RegWrite  out  1 each  IR, PC and register-file write enables.
REQ-010 ALUsrcA  out  2  ALU A operand: 00 PC, 01 oldPC, 10 rs1, 11 zero.
REQ-011 ALUsrcB  out  2  ALU B operand: 00 rs2, 01 imm, 10 constant 4.
REQ-012 ALUctrl  out  3  ALU operation: 000 add, 001 sub.
REQ-013 ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-014 result_src  out  2  result bus source: 00 ALUOut, 01 memory data, 10 ALU result.
REQ-015 illegal  out  1  sticky flag: unsupported opcode or funct decoded.
REQ-016 state  out  4  current state encoding, for debug.

Function
REQ-017 The block SHALL be a Moore FSM; every output is a function of the state only, except EQ gating pc_we in BRANCH and mem_ready gating ir_we/pc_we in FETCH.
REQ-018 Supported instructions: add, sub, addi, lw, sw, beq, bne, jal, lui; any other opcode/funct3/funct7 combination SHALL go DECODE->TRAP.
REQ-019 FETCH: mem_req=1, adr_src=0, ALUsrcA=00, ALUsrcB=10, ALUctrl=add, result_src=10. FSM stays in FETCH while mem_ready=0; in the cycle mem_ready=1, ir_we=pc_we=1 and next state is DECODE.
REQ-020 DECODE: ALUsrcA=01, ALUsrcB=01, ImmSrc=B (J for jal); precomputes branch/jump target into ALUOut. Next state by opcode: R->EXEC_R, addi/lui->EXEC_I, lw/sw->MEM_ADR, branch->BRANCH, jal->JAL.
REQ-021 EXEC_R: A=10, B=00, ALUctrl = sub if funct7=0100000, else add; next WB_ALU.
REQ-022 EXEC_I: A=10 (11 for lui), B=01, ImmSrc=I (U for lui), add; next WB_ALU.
REQ-023 MEM_ADR: A=10, B=01, ImmSrc=I for lw, S for sw, add; next MEM_RD for lw, MEM_WR for sw.
REQ-024 MEM_RD / MEM_WR: mem_req=1, adr_src=1, mem_we=1 in MEM_WR only; hold until mem_ready=1; then MEM_RD->WB_MEM, MEM_WR->FETCH.
REQ-025 WB_ALU: RegWrite=1, result_src=00. WB_MEM: RegWrite=1, result_src=01. Both go to FETCH next.
REQ-026 BRANCH: A=10, B=00, sub, result_src=00; pc_we = (beq & EQ) | (bne & ~EQ); next FETCH.
REQ-027 JAL: A=01, B=10, add, result_src=00, pc_we=1; next WB_ALU, which writes the return address oldPC+4.
REQ-028 Latency with zero-wait memory: R/I/jal 4 cycles, lw 5, sw 4, branch 3. Each wait cycle adds exactly 1.
REQ-029 mem_ready while mem_req=0 SHALL be ignored; the address and mem_we SHALL remain stable while mem_req=1.
REQ-030 TRAP: all enables 0, mem_req=0, illegal=1. State is absorbing until reset.
REQ-031 At most one of RegWrite, mem_we SHALL be high in any cycle; pc_we SHALL be high at most once per instruction outside FETCH.

Reset
REQ-032 rst=0 SHALL force state=FETCH and illegal=0 immediately; all enables and mem_req go low while rst=0, including mid-access (no write completes).
REQ-033 After rst deasserts, the first cycle is FETCH with mem_req=1.

Structure
REQ-034 Package mc_pkg SHALL hold the state enum, opcode/funct constants, and the ALUctrl, ImmSrc, src and result_src encodings.
REQ-035 One sub-module, alu_decoder (combinational: op-class + funct3/funct7 -> ALUctrl), SHALL be instantiated.

Verification
REQ-036 Reset: hold rst=0 3 cycles, release -> state=FETCH, mem_req=1, all write enables 0.
REQ-037 add x3,x1,x2 (0x002081B3), mem_ready tied 1 -> FETCH,DECODE,EXEC_R,WB_ALU; RegWrite only in cycle 4; ALUctrl=000.
REQ-038 sub (0x402081B3) with mem_ready low 2 cycles in FETCH -> FETCH held 3 cycles, ir_we/pc_we pulse once, ALUctrl=001 in EXEC_R.
REQ-039 bne x1,x2 (0x00209463): EQ=1 -> no pc_we in BRANCH; EQ=0 -> pc_we=1, result_src=00; 3 cycles each.
REQ-040 lw then sw, each with a 1-cycle wait in memory stage -> lw 6 cycles with adr_src=1; sw 5 cycles with mem_we=1 only in MEM_WR; no RegWrite for sw.
REQ-041 Opcode 0x7F -> TRAP after DECODE, illegal=1 sticky; rst asserted during MEM_WR -> mem_we drops immediately, state=FETCH.
